// File: rtl/sub_serial_nb.sv
// sub_serial_nb: bit-serial n-bit subtractor, {bo, diff} = a - b - bin, LSB first, start/busy/done handshake
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset
//   start - request, accepted in IDLE or DONE
//   a, b  - minuend / subtrahend, captured on the accepting edge
//   bin   - borrow-in, captured on the accepting edge
//   diff  - registered difference (a - b - bin) mod 2^n
//   bo    - registered borrow-out
//   zero  - registered, diff == 0
//   busy  - high while bits are being computed
//   done  - one-cycle pulse when diff/bo/zero update
module sub_serial_nb #(
   parameter int n = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  logic         bin,
   output logic [n-1:0] diff,
   output logic         bo,
   output logic         zero,
   output logic         busy,
   output logic         done
);
   localparam int cw = $clog2(n + 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [n-1:0] ra_q, ra_d, rb_q, rb_d, sr_q, sr_d, diff_q, diff_d;
   logic [cw-1:0] cnt_q, cnt_d;
   logic br_q, br_d, bo_q, bo_d, zero_q, zero_d, d;
   logic [n-1:0] shifted;
   always_comb begin
      state_d = state_q;
      ra_d = ra_q;
      rb_d = rb_q;
      sr_d = sr_q;
      br_d = br_q;
      cnt_d = cnt_q;
      diff_d = diff_q;
      bo_d = bo_q;
      zero_d = zero_q;
      d = ra_q[0] ^ rb_q[0] ^ br_q;
      // new bit enters at the MSB so after n shifts bit 0 sits at the LSB
      shifted = (sr_q >> 1) | (n'(d) << (n - 1));
      if (state_q == RUN) begin
         sr_d = shifted;
         ra_d = ra_q >> 1;
         rb_d = rb_q >> 1;
         br_d = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & br_q);
         cnt_d = cnt_q + cw'(1);
         if (cnt_q == cw'(n - 1)) begin
            diff_d = shifted;
            bo_d = br_d;
            zero_d = shifted == '0;
            state_d = DONE;
         end
      end else if (start) begin
         ra_d = a;
         rb_d = b;
         br_d = bin;
         cnt_d = '0;
         sr_d = '0;
         state_d = RUN;
      end else begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ra_q <= '0;
         rb_q <= '0;
         sr_q <= '0;
         br_q <= 1'b0;
         cnt_q <= '0;
         diff_q <= '0;
         bo_q <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ra_q <= ra_d;
         rb_q <= rb_d;
         sr_q <= sr_d;
         br_q <= br_d;
         cnt_q <= cnt_d;
         diff_q <= diff_d;
         bo_q <= bo_d;
         zero_q <= zero_d;
      end
   end
   assign diff = diff_q;
   assign bo = bo_q;
   assign zero = zero_q;
   assign busy = state_q == RUN;
   assign done = state_q == DONE;
endmodule

// File: tb/tb_sub_serial_nb.sv
// tb_sub_serial_nb: directed and random checks of sub_serial_nb at n = 1, 8, 16
module tb_sub_serial_nb;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
   logic diff1, bo1, zero1, busy1, done1;
   logic start8 = 1'b0, bin8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0, diff8;
   logic bo8, zero8, busy8, done8;
   logic start16 = 1'b0, bin16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0, diff16;
   logic bo16, zero16, busy16, done16;
   int n_chk = 0;
   int n_fail = 0;
   sub_serial_nb #(.n(1)) u1 (.clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
      .diff(diff1), .bo(bo1), .zero(zero1), .busy(busy1), .done(done1));
   sub_serial_nb #(.n(8)) u8 (.clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
      .diff(diff8), .bo(bo8), .zero(zero8), .busy(busy8), .done(done8));
   sub_serial_nb #(.n(16)) u16 (.clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .bin(bin16),
      .diff(diff16), .bo(bo16), .zero(zero16), .busy(busy16), .done(done16));
   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic bin;
      logic [7:0] d;
      logic bo;
      logic z;
   } vec_t;
   vec_t tbl[10];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin, output int lat, output int bcnt);
      a8 = ta;
      b8 = tb;
      bin8 = tbin;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      lat = 0;
      bcnt = 0;
      while (!done8 && lat < 40) begin
         if (busy8) bcnt++;
         tick();
         lat++;
      end
   endtask
   function automatic logic [8:0] m8(input logic [7:0] ma, input logic [7:0] mb, input logic mbin);
      return {1'b0, ma} - {1'b0, mb} - 9'(mbin);
   endfunction
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int lat, bcnt, extra, cyc;
      logic stable;
      logic [7:0] prev;
      logic [8:0] r8;
      logic [1:0] r1;
      logic [16:0] r16;
      logic [7:0] bb_a[5];
      logic [7:0] bb_b[5];
      logic bb_bin[5];
      tbl[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0};
      tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
      tbl[2] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};
      tbl[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      tbl[4] = '{8'h55, 8'h0A, 1'b0, 8'h4B, 1'b0, 1'b0};
      tbl[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
      tbl[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
      tbl[7] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1};
      tbl[8] = '{8'hA0, 8'h0B, 1'b1, 8'h94, 1'b0, 1'b0};
      tbl[9] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b0};
      #12;
      chk("rst_diff", 32'(diff8), 0);
      chk("rst_bo", 32'(bo8), 0);
      chk("rst_zero", 32'(zero8), 0);
      chk("rst_busy", 32'(busy8), 0);
      chk("rst_done", 32'(done8), 0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      for (int i = 0; i < 10; i++) begin
         run8(tbl[i].a, tbl[i].b, tbl[i].bin, lat, bcnt);
         chk($sformatf("vec%0d_diff", i), 32'(diff8), 32'(tbl[i].d));
         chk($sformatf("vec%0d_bo", i), 32'(bo8), 32'(tbl[i].bo));
         chk($sformatf("vec%0d_zero", i), 32'(zero8), 32'(tbl[i].z));
         chk($sformatf("vec%0d_latency", i), 32'(lat), 8);
         chk($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 8);
         tick();
         chk($sformatf("vec%0d_done_width", i), 32'(done8), 0);
      end
      a8 = 8'hFF;
      b8 = 8'hFF;
      bin8 = 1'b1;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick();
      tick();
      a8 = 8'h12;
      b8 = 8'h01;
      bin8 = 1'b0;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      lat = 3;
      while (!done8 && lat < 40) begin
         tick();
         lat++;
      end
      chk("ign_latency", 32'(lat), 8);
      chk("ign_diff", 32'(diff8), 32'hFF);
      chk("ign_bo", 32'(bo8), 1);
      extra = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done8) extra++;
      end
      chk("ign_extra_done", 32'(extra), 0);
      chk("ign_diff_hold", 32'(diff8), 32'hFF);
      chk("ign_busy_idle", 32'(busy8), 0);
      a8 = 8'h55;
      b8 = 8'h0A;
      bin8 = 1'b0;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick();
      tick();
      tick();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_diff", 32'(diff8), 0);
      chk("arst_bo", 32'(bo8), 0);
      chk("arst_zero", 32'(zero8), 0);
      chk("arst_busy", 32'(busy8), 0);
      chk("arst_done", 32'(done8), 0);
      tick();
      tick();
      @(negedge clk);
      rst = 1'b0;
      extra = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done8 || busy8) extra++;
      end
      chk("arst_no_done", 32'(extra), 0);
      run8(8'h55, 8'h0A, 1'b0, lat, bcnt);
      chk("arst_retry_diff", 32'(diff8), 32'h4B);
      chk("arst_retry_latency", 32'(lat), 8);
      tick();
      bb_a = '{8'h10, 8'h03, 8'hC8, 8'h40, 8'h99};
      bb_b = '{8'h01, 8'h04, 8'h64, 8'h40, 8'h11};
      bb_bin = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      prev = 8'h4B;
      a8 = bb_a[0];
      b8 = bb_b[0];
      bin8 = bb_bin[0];
      start8 = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         cyc = 0;
         stable = 1'b1;
         while (!done8 && cyc < 40) begin
            if (diff8 !== prev) stable = 1'b0;
            tick();
            cyc++;
         end
         r8 = m8(bb_a[i], bb_b[i], bb_bin[i]);
         chk($sformatf("bb%0d_result", i), 32'({bo8, diff8}), 32'(r8));
         chk($sformatf("bb%0d_stable", i), 32'(stable), 1);
         chk($sformatf("bb%0d_period", i), 32'(cyc + 1), 9);
         prev = r8[7:0];
         if (i < 4) begin
            a8 = bb_a[i+1];
            b8 = bb_b[i+1];
            bin8 = bb_bin[i+1];
         end else begin
            start8 = 1'b0;
         end
         tick();
      end
      chk("bb_end_done", 32'(done8), 0);
      chk("bb_end_busy", 32'(busy8), 0);
      a1 = 1'b1;
      b1 = 1'b0;
      bin1 = 1'b0;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("n1_busy", 32'(busy1), 1);
      chk("n1_done_early", 32'(done1), 0);
      tick();
      chk("n1_done", 32'(done1), 1);
      chk("n1_diff", 32'(diff1), 1);
      chk("n1_bo", 32'(bo1), 0);
      chk("n1_busy_done", 32'(busy1), 0);
      tick();
      chk("n1_done_width", 32'(done1), 0);
      a16 = 16'h1000;
      b16 = 16'h0001;
      bin16 = 1'b1;
      start16 = 1'b1;
      tick();
      start16 = 1'b0;
      lat = 0;
      while (!done16 && lat < 40) begin
         tick();
         lat++;
      end
      chk("n16_latency", 32'(lat), 16);
      chk("n16_diff", 32'(diff16), 32'h0FFE);
      chk("n16_bo", 32'(bo16), 0);
      tick();
      for (int i = 0; i < 1000; i++) begin
         a1 = 1'($urandom);
         b1 = 1'($urandom);
         bin1 = 1'($urandom);
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         bin8 = 1'($urandom);
         a16 = 16'($urandom);
         b16 = 16'($urandom);
         bin16 = 1'($urandom);
         if (i % 10 == 0) b8 = a8;
         r1 = {1'b0, a1} - {1'b0, b1} - 2'(bin1);
         r8 = m8(a8, b8, bin8);
         r16 = {1'b0, a16} - {1'b0, b16} - 17'(bin16);
         start1 = 1'b1;
         start8 = 1'b1;
         start16 = 1'b1;
         tick();
         start1 = 1'b0;
         start8 = 1'b0;
         start16 = 1'b0;
         lat = 0;
         while (!done16 && lat < 40) begin
            tick();
            lat++;
         end
         chk("rnd16_latency", 32'(lat), 16);
         chk("rnd1_result", 32'({bo1, diff1}), 32'(r1));
         chk("rnd1_zero", 32'(zero1), 32'(r1[0] == 1'b0));
         chk("rnd8_result", 32'({bo8, diff8}), 32'(r8));
         chk("rnd8_zero", 32'(zero8), 32'(r8[7:0] == 8'h00));
         chk("rnd16_result", 32'({bo16, diff16}), 32'(r16));
         chk("rnd16_zero", 32'(zero16), 32'(r16[15:0] == 16'h0000));
         tick();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sub_serial_nb.md
# sub_serial_nb

Multi-cycle, bit-serial n-bit subtractor: computes {bo, diff} = a − b − bin one bit per clock, LSB first, behind a start/busy/done handshake. It is the subtract-side counterpart to the single-cycle n-bit adder. It serves datapaths where a single full-width borrow chain is too long, or where area matters more than latency. Operands are captured at start. Results are held stable until the next accepted start.

## Interface
Parameters:
- n, default 8: operand/result width in bits; legal range n ≥ 1

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on a rising edge while idle
- a  input  n  minuend; captured on the edge that accepts start
- b  input  n  subtrahend; captured on the edge that accepts start
- bin  input  1  borrow-in; captured on the edge that accepts start
- diff  output  n  registered difference, (a − b − bin) mod 2^n
- bo  output  1  registered borrow-out; 1 iff a < b + bin (unsigned)
- zero  output  1  registered; 1 iff diff == 0 for the latched result
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse when diff/bo/zero are updated

## Operation
- Reset (async, immediate): state = IDLE; diff = 0, bo = 0, zero = 0, busy = 0, done = 0; internal shift registers and counter cleared.
- Reset asserted mid-operation aborts the subtraction; no done pulse; outputs return to reset values.
- States: IDLE, RUN, DONE.
- IDLE: if start = 1 at the edge:
  - capture a, b, bin into internal registers ra, rb, br
  - clear bit counter cnt (width $clog2(n+1)) and the internal result shift register
  - go to RUN
  - otherwise stay in IDLE
- RUN, each edge:
  - d = ra[0] ^ rb[0] ^ br
  - br ← (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br)
  - shift d into the MSB of the result shift register, shifting right
  - shift ra and rb right by 1; cnt ← cnt + 1
  - on the edge where cnt reaches n − 1 (the n-th bit computed):
    - load diff with the full shift register, including that bit
    - load bo with the final borrow
    - load zero with (diff == 0)
    - go to DONE
- DONE: done = 1 for exactly this one cycle; next edge returns to IDLE.
  - start = 1 while in DONE is accepted as in IDLE: operands are captured and the next state is RUN.
- start while in RUN is ignored; no effect on the current operation or on a later one.
- diff, bo and zero are never modified except at completion or reset. Intermediate bits are not visible.
- Width rule: the result equals the low n+1 bits of the two's-complement value a − b − bin, with bo as bit n (equivalently, bo = ~carry-out of a + ~b + ~bin).

## Timing
- Define the accepting edge as E0.
- busy = 1 from after E0 through after edge E(n−1), and 0 in IDLE and DONE.
- Results and done become valid after edge E(n); latency is n cycles from accept to done.
- done is high for one cycle: E(n) to E(n+1).
- Back-to-back operation: start held high in the done cycle gives a throughput of one result per n+1 cycles.
- a, b and bin may change freely after E0.
- For n = 1: RUN lasts one cycle, and done rises one cycle after E0.

## Test plan
- n=8, a=0x35, b=0x12, bin=0, single start pulse:
  - diff=0x23, bo=0, zero=0
  - done high exactly 8 cycles after the accepting edge, for 1 cycle
  - busy high for 8 cycles
- n=8, a=0x00, b=0x01, bin=0: diff=0xFF, bo=1, zero=0. Then a=0x80, b=0x7F, bin=1: diff=0x00, bo=0, zero=1.
- n=8, a=0xFF, b=0xFF, bin=1: diff=0xFF, bo=1. Pulse start again during cycle 3 of RUN with different operands: ignored; the first result is unchanged and no extra done pulse occurs.
- Assert rst at cycle 4 of RUN (a=0x55, b=0x0A):
  - all outputs go to 0 immediately, before the next edge
  - no done pulse
  - after rst is released, a new start produces the correct result 0x4B
- Hold start=1 continuously with new operands presented on each done:
  - done pulses every 9 cycles
  - each diff/bo matches its operands
  - diff stays stable between pulses
- n=1, n=8 and n=16, 1000 random {a, b, bin} each: {bo, diff} matches (a − b − bin) mod 2^(n+1) every time, and zero == (diff == 0).
